// File: rtl/midi_pkg.sv
// Shared constants for the multi-channel MIDI UART:
// register map, STATUS bit layout and RX/TX state encodings.
package midi_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;

    localparam int ST_TX_LVL    = 8;
    localparam int ST_RX_OVF    = 16;
    localparam int ST_FRAME_ERR = 17;
    localparam int ST_TX_OVF    = 18;
    localparam int ST_TX_BUSY   = 19;

    typedef enum logic [1:0] {
        RX_IDLE, RX_START, RX_DATA, RX_STOP
    } rx_state_e;

    typedef enum logic [1:0] {
        TX_IDLE, TX_START, TX_DATA, TX_STOP
    } tx_state_e;

endpackage

// File: rtl/midi_wb_if.sv
// Wishbone slot bundle for the MIDI peripheral.
// The master drives the cycle; the slave answers with ack/rdata.
interface midi_wb_if #(
    parameter int DW = 32
);
    logic [3:0]    wb_addr;
    logic [DW-1:0] wb_rdata;
    logic [DW-1:0] wb_wdata;
    logic          wb_we;
    logic          wb_cyc;
    logic          wb_ack;

    modport master (
        output wb_addr, wb_wdata, wb_we, wb_cyc,
        input  wb_rdata, wb_ack
    );

    modport slave (
        input  wb_addr, wb_wdata, wb_we, wb_cyc,
        output wb_rdata, wb_ack
    );
endinterface

// File: rtl/fifo_sync_ram.sv
// Synchronous FIFO with a show-ahead head word.
// A pop on a full FIFO frees the slot for a same-cycle push.
module fifo_sync_ram #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic [AW:0]  level,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]  mem_q [2**AW];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   lvl_q, lvl_d;
    logic          do_push, do_pop;

    assign empty   = (lvl_q == '0);
    assign full    = lvl_q[AW];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem_q[rd_q];
    assign level   = lvl_q;

    // Pointer and level bookkeeping
    always_comb begin
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        lvl_d = lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage needs no reset; only the pointers do
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

    // Pointer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            lvl_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            lvl_q <= lvl_d;
        end
    end
endmodule

// File: rtl/midi_chan.sv
// One 8N1 MIDI port: input synchroniser, RX/TX shifters,
// TX/RX FIFOs and the sticky error flags.
module midi_chan
    import midi_pkg::*;
#(
    parameter int DIV = 767,
    parameter int AW  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_in,
    output logic        tx_out,
    input  logic        tx_push,
    input  logic [7:0]  tx_wdata,
    input  logic        rx_pop,
    output logic [7:0]  rx_rdata,
    input  logic        clr_rx_ovf,
    input  logic        clr_frame_err,
    input  logic        clr_tx_ovf,
    output logic [AW:0] rx_level,
    output logic [AW:0] tx_level,
    output logic        rx_ovf,
    output logic        frame_err,
    output logic        tx_ovf,
    output logic        tx_busy
);
    localparam int CW = $clog2(DIV + 1);
    localparam logic [CW-1:0] CNT_DIV  = CW'(DIV);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

    logic          sync1_q, sync2_q;
    rx_state_e     rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_push, fe_set;
    tx_state_e     tx_st_q, tx_st_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [2:0]    tx_bit_q, tx_bit_d;
    logic [7:0]    tx_sh_q, tx_sh_d;
    logic          tx_o_q, tx_o_d, tx_pop;
    logic [7:0]    tx_head;
    logic          rx_full, rx_empty, tx_full, tx_empty;
    logic          rx_ovf_q, rx_ovf_d, fe_q, fe_d, tx_ovf_q, tx_ovf_d;

    fifo_sync_ram #(.W(8), .AW(AW)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop),
        .wdata(rx_sh_q), .rdata(rx_rdata), .level(rx_level),
        .full(rx_full), .empty(rx_empty)
    );

    fifo_sync_ram #(.W(8), .AW(AW)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop),
        .wdata(tx_wdata), .rdata(tx_head), .level(tx_level),
        .full(tx_full), .empty(tx_empty)
    );

    // Receiver: mid-bit sampling off the synchronised line
    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_push  = 1'b0;
        fe_set   = 1'b0;
        unique case (rx_st_q)
            RX_IDLE: if (!sync2_q) begin
                rx_cnt_d = CNT_HALF;
                rx_st_d  = RX_START;
            end
            RX_START: if (rx_cnt_q != '0) begin
                rx_cnt_d = rx_cnt_q - CW'(1);
            end else if (!sync2_q) begin
                rx_cnt_d = CNT_DIV;
                rx_bit_d = '0;
                rx_st_d  = RX_DATA;
            end else begin
                rx_st_d = RX_IDLE;
            end
            RX_DATA: if (rx_cnt_q != '0) begin
                rx_cnt_d = rx_cnt_q - CW'(1);
            end else begin
                rx_sh_d  = {sync2_q, rx_sh_q[7:1]};
                rx_cnt_d = CNT_DIV;
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q != '0) begin
                rx_cnt_d = rx_cnt_q - CW'(1);
            end else begin
                rx_push = sync2_q;
                fe_set  = ~sync2_q;
                rx_st_d = RX_IDLE;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    // Transmitter: stop bit chains straight into the next start
    always_comb begin
        tx_st_d  = tx_st_q;
        tx_cnt_d = tx_cnt_q;
        tx_bit_d = tx_bit_q;
        tx_sh_d  = tx_sh_q;
        tx_o_d   = tx_o_q;
        tx_pop   = 1'b0;
        unique case (tx_st_q)
            TX_IDLE: if (!tx_empty) begin
                tx_pop   = 1'b1;
                tx_sh_d  = tx_head;
                tx_cnt_d = CNT_DIV;
                tx_o_d   = 1'b0;
                tx_st_d  = TX_START;
            end
            TX_START: if (tx_cnt_q != '0) begin
                tx_cnt_d = tx_cnt_q - CW'(1);
            end else begin
                tx_cnt_d = CNT_DIV;
                tx_bit_d = '0;
                tx_o_d   = tx_sh_q[0];
                tx_st_d  = TX_DATA;
            end
            TX_DATA: if (tx_cnt_q != '0) begin
                tx_cnt_d = tx_cnt_q - CW'(1);
            end else begin
                tx_cnt_d = CNT_DIV;
                if (tx_bit_q == 3'd7) begin
                    tx_o_d  = 1'b1;
                    tx_st_d = TX_STOP;
                end else begin
                    tx_bit_d = tx_bit_q + 3'd1;
                    tx_sh_d  = {1'b0, tx_sh_q[7:1]};
                    tx_o_d   = tx_sh_q[1];
                end
            end
            TX_STOP: if (tx_cnt_q != '0) begin
                tx_cnt_d = tx_cnt_q - CW'(1);
            end else if (!tx_empty) begin
                tx_pop   = 1'b1;
                tx_sh_d  = tx_head;
                tx_cnt_d = CNT_DIV;
                tx_o_d   = 1'b0;
                tx_st_d  = TX_START;
            end else begin
                tx_o_d  = 1'b1;
                tx_st_d = TX_IDLE;
            end
            default: tx_st_d = TX_IDLE;
        endcase
    end

    // Stickies: a new event wins over a same-cycle clear
    always_comb begin
        rx_ovf_d = (rx_ovf_q & ~clr_rx_ovf) | (rx_push & rx_full & ~rx_pop);
        fe_d     = (fe_q & ~clr_frame_err) | fe_set;
        tx_ovf_d = (tx_ovf_q & ~clr_tx_ovf) | (tx_push & tx_full & ~tx_pop);
    end

    // State registers; reset drops any frame in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            rx_st_q  <= RX_IDLE;
            rx_cnt_q <= '0;
            rx_bit_q <= '0;
            rx_sh_q  <= '0;
            tx_st_q  <= TX_IDLE;
            tx_cnt_q <= '0;
            tx_bit_q <= '0;
            tx_sh_q  <= '0;
            tx_o_q   <= 1'b1;
            rx_ovf_q <= 1'b0;
            fe_q     <= 1'b0;
            tx_ovf_q <= 1'b0;
        end else begin
            sync1_q  <= rx_in;
            sync2_q  <= sync1_q;
            rx_st_q  <= rx_st_d;
            rx_cnt_q <= rx_cnt_d;
            rx_bit_q <= rx_bit_d;
            rx_sh_q  <= rx_sh_d;
            tx_st_q  <= tx_st_d;
            tx_cnt_q <= tx_cnt_d;
            tx_bit_q <= tx_bit_d;
            tx_sh_q  <= tx_sh_d;
            tx_o_q   <= tx_o_d;
            rx_ovf_q <= rx_ovf_d;
            fe_q     <= fe_d;
            tx_ovf_q <= tx_ovf_d;
        end
    end

    assign tx_out    = tx_o_q;
    assign rx_ovf    = rx_ovf_q;
    assign frame_err = fe_q;
    assign tx_ovf    = tx_ovf_q;
    assign tx_busy   = (tx_st_q != TX_IDLE) | ~tx_empty;
endmodule

// File: rtl/midi_wb.sv
// N_CH-port MIDI UART on one Wishbone slot.
// addr[3:2] picks the channel, addr[1:0] the register.
module midi_wb
    import midi_pkg::*;
#(
    parameter int N_CH    = 2,
    parameter int DIV     = 767,
    parameter int FIFO_AW = 4,
    parameter int DW      = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] midi_rx,
    output logic [N_CH-1:0] midi_tx,
    midi_wb_if.slave        wb,
    output logic            irq
);
    logic [1:0]        ch_idx, reg_idx;
    logic              acc, wr, rd;
    logic              ack_q, ack_d, irq_q, irq_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic [N_CH-1:0]   sel, tx_push, rx_pop;
    logic [N_CH-1:0]   clr_rx, clr_fe, clr_tx;
    logic [N_CH-1:0]   rx_ovf, fe, tx_ovf, tx_busy, irq_src;
    logic [N_CH-1:0]   rx_ie_q, rx_ie_d, tx_ie_q, tx_ie_d;
    logic [7:0]        rx_data [N_CH];
    logic [FIFO_AW:0]  rx_lvl [N_CH];
    logic [FIFO_AW:0]  tx_lvl [N_CH];
    logic              unused_wdata;

    assign ch_idx  = wb.wb_addr[3:2];
    assign reg_idx = wb.wb_addr[1:0];
    assign acc     = wb.wb_cyc & ~ack_q;
    assign wr      = acc & wb.wb_we;
    assign rd      = acc & ~wb.wb_we;
    assign unused_wdata = ^{wb.wb_wdata[DW-1:19], wb.wb_wdata[15:8]};

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign sel[i]     = (ch_idx == 2'(i));
        assign tx_push[i] = wr & sel[i] & (reg_idx == REG_DATA);
        assign rx_pop[i]  = rd & sel[i] & (reg_idx == REG_DATA);
        assign clr_rx[i]  = wr & sel[i] & (reg_idx == REG_CTRL) & wb.wb_wdata[16];
        assign clr_fe[i]  = wr & sel[i] & (reg_idx == REG_CTRL) & wb.wb_wdata[17];
        assign clr_tx[i]  = wr & sel[i] & (reg_idx == REG_CTRL) & wb.wb_wdata[18];
        assign irq_src[i] = (rx_ie_q[i] & (rx_lvl[i] != '0))
                          | (tx_ie_q[i] & ~tx_busy[i]);

        midi_chan #(.DIV(DIV), .AW(FIFO_AW)) u_chan (
            .clk(clk), .rst(rst),
            .rx_in(midi_rx[i]), .tx_out(midi_tx[i]),
            .tx_push(tx_push[i]), .tx_wdata(wb.wb_wdata[7:0]),
            .rx_pop(rx_pop[i]), .rx_rdata(rx_data[i]),
            .clr_rx_ovf(clr_rx[i]), .clr_frame_err(clr_fe[i]),
            .clr_tx_ovf(clr_tx[i]),
            .rx_level(rx_lvl[i]), .tx_level(tx_lvl[i]),
            .rx_ovf(rx_ovf[i]), .frame_err(fe[i]),
            .tx_ovf(tx_ovf[i]), .tx_busy(tx_busy[i])
        );
    end

    // CTRL enables
    always_comb begin
        rx_ie_d = rx_ie_q;
        tx_ie_d = tx_ie_q;
        for (int i = 0; i < N_CH; i++) begin
            if (wr && sel[i] && reg_idx == REG_CTRL) begin
                rx_ie_d[i] = wb.wb_wdata[0];
                tx_ie_d[i] = wb.wb_wdata[1];
            end
        end
    end

    // Read mux; zero outside the access cycle and for absent channels
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (rd && sel[i]) begin
                case (reg_idx)
                    REG_DATA: begin
                        if (rx_lvl[i] == '0) rdata_d[DW-1] = 1'b1;
                        else rdata_d[7:0] = rx_data[i];
                    end
                    REG_STATUS: begin
                        rdata_d[FIFO_AW:0]                 = rx_lvl[i];
                        rdata_d[ST_TX_LVL +: FIFO_AW+1]    = tx_lvl[i];
                        rdata_d[ST_RX_OVF]                 = rx_ovf[i];
                        rdata_d[ST_FRAME_ERR]              = fe[i];
                        rdata_d[ST_TX_OVF]                 = tx_ovf[i];
                        rdata_d[ST_TX_BUSY]                = tx_busy[i];
                    end
                    REG_CTRL: begin
                        rdata_d[0] = rx_ie_q[i];
                        rdata_d[1] = tx_ie_q[i];
                    end
                    default: rdata_d = '0;
                endcase
            end
        end
    end

    // Single-cycle ack and registered irq
    always_comb begin
        ack_d = wb.wb_cyc & ~ack_q;
        irq_d = |irq_src;
    end

    // Bus-side registers
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
            rx_ie_q <= '0;
            tx_ie_q <= '0;
        end else begin
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
            rx_ie_q <= rx_ie_d;
            tx_ie_q <= tx_ie_d;
        end
    end

    assign wb.wb_ack   = ack_q;
    assign wb.wb_rdata = rdata_q;
    assign irq         = irq_q;
endmodule

// File: tb/tb_midi_wb.sv
// Directed bench for midi_wb with DIV=7 (8-cycle bits),
// FIFO_AW=2 (4-deep FIFOs) and two channels.
module tb_midi_wb;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] midi_rx = 2'b11;
    logic [1:0] midi_tx;
    logic       irq;
    int         vectors = 0;
    int         miscompares = 0;
    logic [31:0] r;

    midi_wb_if #(.DW(32)) bus ();

    midi_wb #(.N_CH(2), .DIV(7), .FIFO_AW(2), .DW(32)) dut (
        .clk(clk), .rst(rst), .midi_rx(midi_rx),
        .midi_tx(midi_tx), .wb(bus), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic bus_xfer(input logic [3:0] a, input logic we,
                            input logic [31:0] d, output logic [31:0] q);
        int n;
        @(negedge clk);
        bus.wb_addr  = a;
        bus.wb_we    = we;
        bus.wb_wdata = d;
        bus.wb_cyc   = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (bus.wb_ack !== 1'b1 && n < 8);
        vectors++;
        if (bus.wb_ack !== 1'b1) begin
            miscompares++;
            $display("FAIL bus_ack addr=%h: got %b, expected 1 within 8 cycles", a, bus.wb_ack);
        end
        q = bus.wb_rdata;
        bus.wb_cyc = 1'b0;
        bus.wb_we  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        bus_xfer(a, 1'b1, d, dummy);
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] q);
        bus_xfer(a, 1'b0, 32'h0, q);
    endtask

    task automatic send_byte(input int ch, input logic [7:0] b, input logic stop);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            midi_rx[ch] = fr[k];
            repeat (8) @(negedge clk);
        end
        midi_rx[ch] = 1'b1;
    endtask

    task automatic run_len(input int ch, input logic v, input int cap, output int n);
        n = 0;
        while (midi_tx[ch] === v && n < cap) begin
            n++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (midi_tx !== 2'b11 || bus.wb_ack !== 1'b0 || bus.wb_rdata !== 32'h0 || irq !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: got tx=%b ack=%b rdata=%h irq=%b, expected 11 0 0 0",
                     midi_tx, bus.wb_ack, bus.wb_rdata, irq);
        end
        rd(4'h1, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_status0: got %h, expected 00000000", r);
        end
        rd(4'h5, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_status1: got %h, expected 00000000", r);
        end
        rd(4'h2, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_ctrl0: got %h, expected 00000000", r);
        end
    endtask

    task automatic test_tx;
        int n, n0, n1, n2, n3;
        logic tx1_low;
        tx1_low = 1'b0;
        wr(4'h0, 32'h90);
        n = 0;
        while (midi_tx[0] !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        fork
            begin
                run_len(0, 1'b0, 200, n0);
                run_len(0, 1'b1, 200, n1);
                run_len(0, 1'b0, 200, n2);
                run_len(0, 1'b1, 40, n3);
            end
            begin
                repeat (110) begin
                    @(negedge clk);
                    if (midi_tx[1] !== 1'b1) tx1_low = 1'b1;
                end
            end
        join
        vectors++;
        if (n0 != 40 || n1 != 8 || n2 != 16 || n3 != 40) begin
            miscompares++;
            $display("FAIL tx_0x90_runs: got %0d/%0d/%0d/%0d, expected 40/8/16/40", n0, n1, n2, n3);
        end
        vectors++;
        if (tx1_low !== 1'b0) begin
            miscompares++;
            $display("FAIL tx_ch1_idle: got low=%b, expected 0", tx1_low);
        end
        rd(4'h1, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL tx_done_status: got %h, expected 00000000", r);
        end
    endtask

    task automatic test_rx;
        send_byte(1, 8'h3C, 1'b1);
        repeat (4) @(posedge clk);
        rd(4'h5, r);
        vectors++;
        if (r !== 32'h0000_0001) begin
            miscompares++;
            $display("FAIL rx_level: got %h, expected 00000001", r);
        end
        rd(4'h4, r);
        vectors++;
        if (r !== 32'h0000_003C) begin
            miscompares++;
            $display("FAIL rx_data: got %h, expected 0000003c", r);
        end
        rd(4'h4, r);
        vectors++;
        if (r !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL rx_empty_read: got %h, expected 80000000", r);
        end
    endtask

    task automatic test_rx_overflow;
        logic [7:0] exp_b [5];
        exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) send_byte(1, exp_b[i], 1'b1);
        repeat (4) @(posedge clk);
        rd(4'h5, r);
        vectors++;
        if (r !== 32'h0001_0004) begin
            miscompares++;
            $display("FAIL ovf_status: got %h, expected 00010004", r);
        end
        for (int i = 0; i < 4; i++) begin
            rd(4'h4, r);
            vectors++;
            if (r !== {24'h0, exp_b[i]}) begin
                miscompares++;
                $display("FAIL ovf_byte%0d: got %h, expected %h", i, r, {24'h0, exp_b[i]});
            end
        end
        wr(4'h6, 32'h0001_0000);
        rd(4'h5, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL ovf_clear: got %h, expected 00000000", r);
        end
    endtask

    task automatic test_frame_err;
        send_byte(0, 8'hA5, 1'b0);
        repeat (10) @(posedge clk);
        rd(4'h1, r);
        vectors++;
        if (r !== 32'h0002_0000) begin
            miscompares++;
            $display("FAIL frame_err: got %h, expected 00020000", r);
        end
        wr(4'h2, 32'h0002_0000);
        @(negedge clk);
        midi_rx[0] = 1'b0;
        repeat (2) @(negedge clk);
        midi_rx[0] = 1'b1;
        repeat (20) @(posedge clk);
        rd(4'h1, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL glitch_status: got %h, expected 00000000", r);
        end
        rd(4'h0, r);
        vectors++;
        if (r !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL glitch_data: got %h, expected 80000000", r);
        end
    endtask

    task automatic test_bus;
        int acks, n, lo, hi;
        @(negedge clk);
        bus.wb_addr  = 4'h4;
        bus.wb_we    = 1'b1;
        bus.wb_wdata = 32'h0;
        bus.wb_cyc   = 1'b1;
        acks = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (bus.wb_ack === 1'b1) acks++;
        end
        bus.wb_cyc = 1'b0;
        bus.wb_we  = 1'b0;
        vectors++;
        if (acks != 1) begin
            miscompares++;
            $display("FAIL bus_one_ack: got %0d acks, expected 1", acks);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (bus.wb_ack !== 1'b0 || bus.wb_rdata !== 32'h0) begin
            miscompares++;
            $display("FAIL bus_idle: got ack=%b rdata=%h, expected 0 00000000", bus.wb_ack, bus.wb_rdata);
        end
        n = 0;
        while (midi_tx[1] !== 1'b0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        run_len(1, 1'b0, 200, lo);
        run_len(1, 1'b1, 60, hi);
        vectors++;
        if (lo != 72 || hi != 60) begin
            miscompares++;
            $display("FAIL bus_single_push: got low=%0d high=%0d, expected 72 60", lo, hi);
        end
        rd(4'hC, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL ch3_data: got %h, expected 00000000", r);
        end
        rd(4'hD, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL ch3_status: got %h, expected 00000000", r);
        end
        wr(4'h8, 32'h55);
        rd(4'h1, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL ch2_write_ignored: got %h, expected 00000000", r);
        end
    endtask

    task automatic test_irq;
        logic [7:0] irqs;
        logic [8:0] fr;
        wr(4'h2, 32'h1);
        @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_idle: got %b, expected 0", irq);
        end
        fr = {8'h5A, 1'b0};
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            midi_rx[0] = fr[k];
            repeat (8) @(negedge clk);
        end
        midi_rx[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            irqs[k] = irq;
        end
        vectors++;
        if (irqs[6] !== 1'b0 || irqs[7] !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_rx_latency: got %b%b, expected 01", irqs[6], irqs[7]);
        end
        rd(4'h0, r);
        vectors++;
        if (r !== 32'h0000_005A) begin
            miscompares++;
            $display("FAIL irq_rx_data: got %h, expected 0000005a", r);
        end
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_after_pop: got %b, expected 0", irq);
        end
        wr(4'h2, 32'h0);
        wr(4'h6, 32'h0007_0002);
        @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b1) begin
            miscompares++;
            $display("FAIL irq_tx_empty: got %b, expected 1", irq);
        end
        rd(4'h6, r);
        vectors++;
        if (r !== 32'h0000_0002) begin
            miscompares++;
            $display("FAIL ctrl_readback: got %h, expected 00000002", r);
        end
        wr(4'h6, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (irq !== 1'b0) begin
            miscompares++;
            $display("FAIL irq_disabled: got %b, expected 0", irq);
        end
    endtask

    task automatic test_reset_mid_tx;
        int lows;
        wr(4'h0, 32'h90);
        wr(4'h0, 32'h33);
        repeat (35) @(posedge clk);
        #1;
        vectors++;
        if (midi_tx[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_tx_bit3: got %b, expected 0", midi_tx[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (midi_tx !== 2'b11) begin
            miscompares++;
            $display("FAIL reset_tx_line: got %b, expected 11", midi_tx);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd(4'h1, r);
        vectors++;
        if (r !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_levels: got %h, expected 00000000", r);
        end
        lows = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (midi_tx[0] !== 1'b1) lows++;
        end
        vectors++;
        if (lows != 0) begin
            miscompares++;
            $display("FAIL no_resume: got %0d low cycles, expected 0", lows);
        end
    endtask

    initial begin
        bus.wb_addr  = 4'h0;
        bus.wb_wdata = 32'h0;
        bus.wb_we    = 1'b0;
        bus.wb_cyc   = 1'b0;
        test_reset();
        test_tx();
        test_rx();
        test_rx_overflow();
        test_frame_err();
        test_bus();
        test_irq();
        test_reset_mid_tx();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
